// File: rtl/dense_layer_ctrl.sv
// dense_layer_ctrl: sequences one dense-layer pass (clear, feed, drain, load,
// serialize, wait for activation) with a one-deep pending request, abort and
// a watchdog over the serializer/activation phases. All outputs are flops.
module dense_layer_ctrl #(
    parameter int unsigned IN_LEN   = 400,
    parameter int unsigned AW       = 9,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          mac_clr,
    output logic          feat_rd_en,
    output logic [AW-1:0] feat_addr,
    output logic          mac_en,
    output logic          mac_load,
    output logic          ser_ena,
    input  logic          ser_frame_end,
    input  logic          act_done,
    output logic          done,
    output logic          err,
    output logic          err_sticky
);

    // Shared cycle counter: drain length and watchdog; headroom above TIMEOUT.
    localparam int unsigned CW = $clog2(TIMEOUT + 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRAIN,
        S_LOAD,
        S_SER,
        S_WAIT_ACT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_pend;
    logic            w_pend_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [AW-1:0]   w_addr_nxt;
    logic            w_err_nxt;
    logic            w_sticky_nxt;
    logic            w_wd_exp;
    logic            w_rd_nxt;
    logic [RD_LAT:0] r_rd_pipe;

    // State, pending flag and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pend  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, pending, counter and next-output decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_pend_nxt   = r_pend;
        w_cnt_nxt    = r_cnt;
        w_addr_nxt   = '0;
        w_err_nxt    = 1'b0;
        w_sticky_nxt = err_sticky;
        w_wd_exp     = (r_cnt >= CW'(TIMEOUT - 1));

        if (start && (r_state != S_IDLE)) begin
            w_pend_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt  = S_CLR;
                    w_sticky_nxt = 1'b0;
                end
            end
            S_CLR: begin
                w_state_nxt = S_FEED;
            end
            S_FEED: begin
                if (feat_addr == AW'(IN_LEN - 1)) begin
                    w_state_nxt = (PIPE_LAT == 0) ? S_LOAD : S_DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_addr_nxt = feat_addr + AW'(1);
                end
            end
            S_DRAIN: begin
                if (r_cnt == CW'(PIPE_LAT - 1)) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_LOAD: begin
                w_state_nxt = S_SER;
                w_cnt_nxt   = '0;
            end
            S_SER: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (ser_frame_end) begin
                    w_state_nxt = S_WAIT_ACT;
                end else if (w_wd_exp) begin
                    w_state_nxt  = S_IDLE;
                    w_cnt_nxt    = '0;
                    w_err_nxt    = 1'b1;
                    w_sticky_nxt = 1'b1;
                    w_pend_nxt   = 1'b0;
                end
            end
            S_WAIT_ACT: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (act_done) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else if (w_wd_exp) begin
                    w_state_nxt  = S_IDLE;
                    w_cnt_nxt    = '0;
                    w_err_nxt    = 1'b1;
                    w_sticky_nxt = 1'b1;
                    w_pend_nxt   = 1'b0;
                end
            end
            S_DONE: begin
                // A start arriving in DONE is queued and consumed right away.
                w_state_nxt = (r_pend || start) ? S_CLR : S_IDLE;
                w_pend_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (abort) begin
            w_state_nxt  = S_IDLE;
            w_pend_nxt   = 1'b0;
            w_cnt_nxt    = '0;
            w_addr_nxt   = '0;
            w_err_nxt    = 1'b0;
            w_sticky_nxt = err_sticky;
        end

        w_rd_nxt = (w_state_nxt == S_FEED);
    end

    // Registered outputs derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            mac_clr    <= 1'b0;
            feat_addr  <= '0;
            mac_load   <= 1'b0;
            ser_ena    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            busy       <= (w_state_nxt != S_IDLE);
            mac_clr    <= (w_state_nxt == S_CLR);
            feat_addr  <= w_addr_nxt;
            mac_load   <= (w_state_nxt == S_LOAD);
            ser_ena    <= (w_state_nxt == S_SER) && (r_state != S_SER);
            done       <= (w_state_nxt == S_DONE);
            err        <= w_err_nxt;
            err_sticky <= w_sticky_nxt;
        end
    end

    // Read-enable flop followed by RD_LAT delay stages to align mac_en.
    generate
        if (RD_LAT == 0) begin : g_no_lat
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_pipe <= '0;
                end else begin
                    r_rd_pipe <= w_rd_nxt;
                end
            end
        end else begin : g_lat
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_pipe <= '0;
                end else if (abort) begin
                    r_rd_pipe <= '0;
                end else begin
                    r_rd_pipe <= {r_rd_pipe[RD_LAT-1:0], w_rd_nxt};
                end
            end
        end
    endgenerate

    assign feat_rd_en = r_rd_pipe[0];
    assign mac_en     = r_rd_pipe[RD_LAT];

endmodule

// File: tb/tb_dense_layer_ctrl.sv
// Testbench for dense_layer_ctrl: directed scenarios plus randomized passes
// checked cycle by cycle against a timeline model built from the pass timing.
module tb_dense_layer_ctrl;

    localparam int unsigned L   = 4;
    localparam int unsigned AWB = 3;
    localparam int unsigned R   = 1;
    localparam int unsigned P   = 2;
    localparam int unsigned T   = 16;
    localparam int          NC  = 128;

    localparam int B_BUSY = 8;
    localparam int B_CLR  = 7;
    localparam int B_RD   = 6;
    localparam int B_MEN  = 5;
    localparam int B_LOAD = 4;
    localparam int B_SENA = 3;
    localparam int B_DONE = 2;
    localparam int B_ERR  = 1;
    localparam int B_STK  = 0;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           ser_frame_end = 1'b0;
    logic           act_done = 1'b0;
    logic           busy, mac_clr, feat_rd_en, mac_en, mac_load, ser_ena, done, err, err_sticky;
    logic [AWB-1:0] feat_addr;

    logic [8:0]     o_vec  [NC];
    logic [8:0]     e_vec  [NC];
    logic [AWB-1:0] o_addr [NC];
    logic [AWB-1:0] e_addr [NC];
    bit             s_start[NC];
    bit             s_abort[NC];
    bit             s_sfe  [NC];
    bit             s_act  [NC];

    int n_cmp = 0;
    int n_bad = 0;
    bit carry = 1'b0;

    always #5 clk = ~clk;

    dense_layer_ctrl #(
        .IN_LEN(L), .AW(AWB), .RD_LAT(R), .PIPE_LAT(P), .TIMEOUT(T)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
        .mac_clr(mac_clr), .feat_rd_en(feat_rd_en), .feat_addr(feat_addr),
        .mac_en(mac_en), .mac_load(mac_load), .ser_ena(ser_ena),
        .ser_frame_end(ser_frame_end), .act_done(act_done), .done(done),
        .err(err), .err_sticky(err_sticky)
    );

    task automatic clear_model();
        for (int c = 0; c < NC; c++) begin
            e_vec[c]   = {8'd0, carry};
            e_addr[c]  = '0;
            s_start[c] = 1'b0;
            s_abort[c] = 1'b0;
            s_sfe[c]   = 1'b0;
            s_act[c]   = 1'b0;
        end
    endtask

    task automatic setb(input int c, input int b);
        if (c >= 0 && c < NC) e_vec[c][b] = 1'b1;
    endtask

    // One pass accepted at t: act_done honoured at a, or watchdog expiry if to.
    task automatic m_pass(input int t, input int a, input bit to);
        int s;
        int last;
        s    = t + 3 + int'(L) + int'(P);
        last = to ? s + int'(T) - 1 : a + 1;
        for (int c = t + 1; c <= last; c++) setb(c, B_BUSY);
        setb(t + 1, B_CLR);
        for (int k = 0; k < int'(L); k++) begin
            setb(t + 2 + k, B_RD);
            if (t + 2 + k < NC) e_addr[t + 2 + k] = AWB'(k);
            setb(t + 2 + int'(R) + k, B_MEN);
        end
        setb(t + 2 + int'(L) + int'(P), B_LOAD);
        setb(s, B_SENA);
        for (int c = t + 1; c < NC; c++) e_vec[c][B_STK] = 1'b0;
        if (to) begin
            setb(s + int'(T), B_ERR);
            for (int c = s + int'(T); c < NC; c++) e_vec[c][B_STK] = 1'b1;
        end else begin
            setb(a + 1, B_DONE);
        end
    endtask

    // Abort at b: everything but err_sticky is quiet from b+1.
    task automatic m_cut(input int b);
        for (int c = b + 1; c < NC; c++) begin
            e_vec[c]  = e_vec[c] & 9'b000000001;
            e_addr[c] = '0;
        end
    endtask

    // Drive the input schedule and record outputs, one sample per cycle.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            o_vec[c]      = {busy, mac_clr, feat_rd_en, mac_en, mac_load, ser_ena, done, err, err_sticky};
            o_addr[c]     = feat_addr;
            start         = s_start[c];
            abort         = s_abort[c];
            ser_frame_end = s_sfe[c];
            act_done      = s_act[c];
            @(posedge clk);
            #1;
        end
        start         = 1'b0;
        abort         = 1'b0;
        ser_frame_end = 1'b0;
        act_done      = 1'b0;
        carry         = e_vec[n-1][B_STK];
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_cmp++;
        if ({busy, mac_clr, feat_rd_en, mac_en, mac_load, ser_ena, done, err, err_sticky} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_outs got %b exp 000000000", {busy, mac_clr, feat_rd_en, mac_en, mac_load, ser_ena, done, err, err_sticky});
        end
        n_cmp++;
        if (feat_addr !== '0) begin
            n_bad++;
            $display("FAIL reset_addr got %0d exp 0", feat_addr);
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_busy got %b exp 0", busy);
        end
    endtask

    task automatic test_nominal();
        clear_model();
        s_start[10] = 1'b1;
        s_sfe[30]   = 1'b1;
        s_act[33]   = 1'b1;
        m_pass(10, 33, 1'b0);
        run(45);
        for (int c = 0; c < 45; c++) begin
            n_cmp++;
            if (o_vec[c] !== e_vec[c]) begin n_bad++; $display("FAIL nominal_outs cyc %0d got %b exp %b", c, o_vec[c], e_vec[c]); end
            n_cmp++;
            if (o_addr[c] !== e_addr[c]) begin n_bad++; $display("FAIL nominal_addr cyc %0d got %0d exp %0d", c, o_addr[c], e_addr[c]); end
        end
    endtask

    task automatic test_pending();
        int ndone;
        clear_model();
        s_start[10] = 1'b1;
        s_start[20] = 1'b1;
        s_start[21] = 1'b1;
        s_sfe[30]   = 1'b1;
        s_act[33]   = 1'b1;
        s_sfe[50]   = 1'b1;
        s_act[53]   = 1'b1;
        m_pass(10, 33, 1'b0);
        m_pass(34, 53, 1'b0);
        run(62);
        ndone = 0;
        for (int c = 0; c < 62; c++) begin
            if (o_vec[c][B_DONE] === 1'b1) ndone++;
            n_cmp++;
            if (o_vec[c] !== e_vec[c]) begin n_bad++; $display("FAIL pending_outs cyc %0d got %b exp %b", c, o_vec[c], e_vec[c]); end
            n_cmp++;
            if (o_addr[c] !== e_addr[c]) begin n_bad++; $display("FAIL pending_addr cyc %0d got %0d exp %0d", c, o_addr[c], e_addr[c]); end
        end
        n_cmp++;
        if (ndone !== 2) begin n_bad++; $display("FAIL pending_pass_count got %0d exp 2", ndone); end
    endtask

    task automatic test_watchdog();
        clear_model();
        s_start[10] = 1'b1;
        s_start[25] = 1'b1;
        s_start[40] = 1'b1;
        s_sfe[55]   = 1'b1;
        s_act[58]   = 1'b1;
        m_pass(10, 0, 1'b1);
        m_pass(40, 58, 1'b0);
        run(65);
        for (int c = 0; c < 65; c++) begin
            n_cmp++;
            if (o_vec[c] !== e_vec[c]) begin n_bad++; $display("FAIL watchdog_outs cyc %0d got %b exp %b", c, o_vec[c], e_vec[c]); end
            n_cmp++;
            if (o_addr[c] !== e_addr[c]) begin n_bad++; $display("FAIL watchdog_addr cyc %0d got %0d exp %0d", c, o_addr[c], e_addr[c]); end
        end
    endtask

    task automatic test_race();
        clear_model();
        s_start[10] = 1'b1;
        s_sfe[25]   = 1'b1;
        s_act[34]   = 1'b1;
        m_pass(10, 34, 1'b0);
        run(42);
        for (int c = 0; c < 42; c++) begin
            n_cmp++;
            if (o_vec[c] !== e_vec[c]) begin n_bad++; $display("FAIL race_outs cyc %0d got %b exp %b", c, o_vec[c], e_vec[c]); end
        end
    endtask

    task automatic test_abort();
        clear_model();
        s_start[10] = 1'b1;
        s_start[12] = 1'b1;
        s_abort[14] = 1'b1;
        s_start[30] = 1'b1;
        s_abort[30] = 1'b1;
        m_pass(10, 200, 1'b0);
        m_cut(14);
        run(45);
        for (int c = 0; c < 45; c++) begin
            n_cmp++;
            if (o_vec[c] !== e_vec[c]) begin n_bad++; $display("FAIL abort_outs cyc %0d got %b exp %b", c, o_vec[c], e_vec[c]); end
            n_cmp++;
            if (o_addr[c] !== e_addr[c]) begin n_bad++; $display("FAIL abort_addr cyc %0d got %0d exp %0d", c, o_addr[c], e_addr[c]); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int mode, t, s, f, a, b, p, t2, s2, f2, a2, n;
            clear_model();
            mode = int'($urandom_range(3, 0));
            t    = int'($urandom_range(6, 1));
            s    = t + 3 + int'(L) + int'(P);
            s_start[t] = 1'b1;
            n = 10;
            case (mode)
                0: begin
                    f = s + int'($urandom_range(13, 0));
                    a = int'($urandom_range(s + 15, f + 1));
                    s_sfe[f] = 1'b1;
                    s_act[a] = 1'b1;
                    s_act[int'($urandom_range(f, t + 1))] = 1'b1;
                    s_sfe[int'($urandom_range(s - 1, t + 1))] = 1'b1;
                    if (a > f + 1) s_sfe[int'($urandom_range(a - 1, f + 1))] = 1'b1;
                    m_pass(t, a, 1'b0);
                    n = a + 6;
                end
                1: begin
                    s_act[int'($urandom_range(s + 14, t + 1))] = 1'b1;
                    m_pass(t, 0, 1'b1);
                    n = s + int'(T) + 4;
                end
                2: begin
                    f = s + 3;
                    a = s + 6;
                    b = int'($urandom_range(a, t));
                    s_sfe[f]   = 1'b1;
                    s_act[a]   = 1'b1;
                    s_abort[b] = 1'b1;
                    if (b != t) begin
                        m_pass(t, a, 1'b0);
                        m_cut(b);
                    end
                    n = a + 6;
                end
                default: begin
                    f  = s + int'($urandom_range(13, 0));
                    a  = int'($urandom_range(s + 15, f + 1));
                    p  = int'($urandom_range(a, t + 1));
                    s_start[p] = 1'b1;
                    s_sfe[f]   = 1'b1;
                    s_act[a]   = 1'b1;
                    m_pass(t, a, 1'b0);
                    t2 = a + 1;
                    s2 = t2 + 3 + int'(L) + int'(P);
                    f2 = s2 + int'($urandom_range(13, 0));
                    a2 = int'($urandom_range(s2 + 15, f2 + 1));
                    s_sfe[f2] = 1'b1;
                    s_act[a2] = 1'b1;
                    m_pass(t2, a2, 1'b0);
                    n = a2 + 6;
                end
            endcase
            run(n);
            for (int c = 0; c < n; c++) begin
                n_cmp++;
                if (o_vec[c] !== e_vec[c]) begin n_bad++; $display("FAIL random_outs it %0d mode %0d cyc %0d got %b exp %b", it, mode, c, o_vec[c], e_vec[c]); end
                n_cmp++;
                if (o_addr[c] !== e_addr[c]) begin n_bad++; $display("FAIL random_addr it %0d mode %0d cyc %0d got %0d exp %0d", it, mode, c, o_addr[c], e_addr[c]); end
            end
        end
    endtask

    task automatic test_reset_midpass();
        clear_model();
        s_start[2] = 1'b1;
        m_pass(2, 200, 1'b0);
        run(14);
        for (int c = 0; c < 14; c++) begin
            n_cmp++;
            if (o_vec[c] !== e_vec[c]) begin n_bad++; $display("FAIL midpass_outs cyc %0d got %b exp %b", c, o_vec[c], e_vec[c]); end
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, mac_clr, feat_rd_en, mac_en, mac_load, ser_ena, done, err, err_sticky} !== 9'd0) begin
            n_bad++;
            $display("FAIL async_reset_outs got %b exp 000000000", {busy, mac_clr, feat_rd_en, mac_en, mac_load, ser_ena, done, err, err_sticky});
        end
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        carry = 1'b0;
        clear_model();
        s_sfe[1] = 1'b1;
        s_act[2] = 1'b1;
        run(10);
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (o_vec[c] !== e_vec[c]) begin n_bad++; $display("FAIL after_reset_outs cyc %0d got %b exp %b", c, o_vec[c], e_vec[c]); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_pending();
        test_watchdog();
        test_race();
        test_abort();
        test_random();
        test_reset_midpass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
